countdown_timer: RTL
====================

# countdown_timer

BCD countdown timer for the snake game's round clock, the down-counting counterpart of the up-counting score/time counters. It loads a two-digit BCD start value, decrements once per `en` tick while running, supports pause and time bonuses, and flags expiry to the game controller. Its digit outputs feed the 7-segment display path in the same BCD format as the existing counters (QH tens in 3 bits, QL units in 4 bits).

## Interface
Parameters:
- INIT_H, 3: tens digit loaded on reset/start (0–7).
- INIT_L, 0: units digit loaded on reset/start (0–9).
- BONUS, 5: seconds added per `bonus` pulse (1–9, BCD units).
- WARN_TH, 5: warning threshold in seconds (BCD 00–79), used only with COUNTDOWN_WARN_EN.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- en  in  1  one-cycle tick strobe (1 Hz prescaler output).
- start  in  1  one-cycle pulse: load INIT and begin counting.
- hold  in  1  level: freeze counting while high.
- bonus  in  1  one-cycle pulse: add BONUS seconds.
- QL  out  4  units digit, BCD 0–9.
- QH  out  3  tens digit, BCD 0–7.
- BW  out  1  borrow/expiry pulse, one cycle.
- RUNNING  out  1  high in RUN or PAUSE.
- EXPIRED  out  1  high in EXPIRED.
- WARN  out  1  low-time warning.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. All outputs registered.
- RESET: state IDLE, QH=INIT_H, QL=INIT_L, BW=0, WARN=0. Overrides all other inputs.
- Priority each cycle: RESET > start > (tick, bonus) > hold transitions.
- start, any state: QH:QL ← INIT_H:INIT_L. Next state is PAUSE if hold=1, otherwise RUN. Any tick or bonus in the same cycle is discarded.
- RUN:
  - hold=1 → PAUSE; an en in that cycle is ignored.
  - en=1 → decrement. If QL≠0 then QL−1; otherwise QL←9 and QH−1.
- PAUSE:
  - hold=0 → RUN; en ignored in that cycle.
  - bonus is still applied.
- Bonus, in RUN or PAUSE:
  - QL+BONUS>9 → QL ← QL+BONUS−10, QH+1.
  - Saturates at 79.
  - Ignored in IDLE and EXPIRED.
- Tick and bonus in the same cycle: net result is value−1+BONUS, with saturation applied last. The count never reaches 00 this way, so no expiry.
- Expiry: a decrement that yields 00 moves to EXPIRED and asserts BW for exactly that one cycle.
- EXPIRED: holds 00 and ignores en, hold and bonus. Only start or RESET leave it.
- IDLE: ignores en, hold and bonus. Displays INIT.
- Digits never leave legal BCD: QL 0–9, QH 0–7.

## Timing
- Tick latency: en high at edge N → new QH:QL visible after edge N.
- BW and EXPIRED rise after the same edge that makes QH:QL=00. BW falls one cycle later.
- Bonus and start take effect at the sampling edge, with 1-cycle output latency.
- RESET mid-count takes effect at the next edge. No BW is generated by reset.

## Configuration
- COUNTDOWN_WARN_EN defined:
  - WARN is registered.
  - WARN=1 when state is RUN or PAUSE and 00 < QH:QL ≤ WARN_TH (BCD compare).
  - WARN updates on the same edge as the count.
- COUNTDOWN_WARN_EN undefined: WARN is tied to 0 and no compare logic is built. The port remains present.

## Test plan
- Reset then start with INIT 30, 30 en ticks → sequence 29, 28 … 10, 09 … 01, 00. BW high exactly on the 00 cycle, EXPIRED=1, RUNNING=0.
- At 12, hold high for 5 cycles with en every cycle → value stays 12, state PAUSE. After hold falls, the next en gives 11.
- Bonus at 07 → 12. Bonus at 77 → 79 (saturation). Bonus and en together at 01 → 05, no BW.
- In EXPIRED, pulse en/bonus → stays 00. Then start with hold=1 → 30, state PAUSE.
- RESET asserted at 15 together with en and start → 30, IDLE, BW=0. Start together with en at 20 → 30, not 29.
- With COUNTDOWN_WARN_EN: WARN rises when count hits 05, stays high through 01, low at 00 and in IDLE. Without the macro, WARN is 0 throughout.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the two-digit BCD round-clock countdown timer.
// The master drives the tick/start/hold/bonus strobes; the slave (the timer) returns digits and status.
interface countdown_timer_if;
  logic       en;
  logic       start;
  logic       hold;
  logic       bonus;
  logic [3:0] QL;
  logic [2:0] QH;
  logic       BW;
  logic       RUNNING;
  logic       EXPIRED;
  logic       WARN;

  modport master (
    output en, start, hold, bonus,
    input  QL, QH, BW, RUNNING, EXPIRED, WARN
  );

  modport slave (
    input  en, start, hold, bonus,
    output QL, QH, BW, RUNNING, EXPIRED, WARN
  );
endinterface

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with pause, time bonus and expiry pulse; all outputs registered.
// Optional low-time warning output is built only when COUNTDOWN_WARN_EN is defined.
module countdown_timer #(
  parameter logic [2:0] INIT_H  = 3'd3,
  parameter logic [3:0] INIT_L  = 4'd0,
  parameter logic [3:0] BONUS   = 4'd5,
  parameter logic [7:0] WARN_TH = 8'h05   // BCD {tens, units}
) (
  input  logic              CLK,
  input  logic              RESET,
  countdown_timer_if.slave  tmr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [6:0] INIT_VAL = {INIT_H, INIT_L};

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;          // {tens[2:0], units[3:0]}
  logic       bw_q, bw_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;

  function automatic logic [6:0] bcd_dec(input logic [6:0] v);
    if (v[3:0] != 4'd0)      return {v[6:4], v[3:0] - 4'd1};
    else if (v[6:4] != 3'd0) return {v[6:4] - 3'd1, 4'd9};
    else                     return 7'd0;
  endfunction

  // Adds BONUS seconds with a units carry; anything past 79 pins at 79.
  function automatic logic [6:0] bcd_add_bonus(input logic [6:0] v);
    logic [4:0] sum;
    logic [4:0] wrapped;
    sum     = {1'b0, v[3:0]} + {1'b0, BONUS};
    wrapped = sum - 5'd10;
    if (sum > 5'd9) begin
      if (v[6:4] == 3'd7) return {3'd7, 4'd9};
      else                return {v[6:4] + 3'd1, wrapped[3:0]};
    end
    return {v[6:4], sum[3:0]};
  endfunction

  always_comb begin
    logic [6:0] dec;
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bw_d    = 1'b0;
    dec     = cnt_q;
    if (tmr.start) begin
      cnt_d   = INIT_VAL;
      state_d = tmr.hold ? ST_PAUSE : ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (tmr.hold) begin
            state_d = ST_PAUSE;
            if (tmr.bonus) cnt_d = bcd_add_bonus(cnt_q);
          end else begin
            dec = tmr.en ? bcd_dec(cnt_q) : cnt_q;
            if (tmr.bonus) begin
              cnt_d = bcd_add_bonus(dec);
            end else begin
              cnt_d = dec;
              if (tmr.en && dec == 7'd0) begin
                state_d = ST_EXPIRED;
                bw_d    = 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (tmr.bonus) cnt_d = bcd_add_bonus(cnt_q);
          if (!tmr.hold) state_d = ST_RUN;
        end
        ST_EXPIRED: cnt_d = 7'd0;
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= INIT_VAL;
      bw_q      <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bw_q      <= bw_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

`ifdef COUNTDOWN_WARN_EN
  logic warn_q, warn_d;

  // Packed BCD digits order the same way as the seconds they encode.
  always_comb begin
    warn_d = running_d && (cnt_d != 7'd0) && ({1'b0, cnt_d} <= WARN_TH);
  end

  always_ff @(posedge CLK) begin
    if (RESET) warn_q <= 1'b0;
    else       warn_q <= warn_d;
  end

  assign tmr.WARN = warn_q;
`else
  assign tmr.WARN = 1'b0;
`endif

  assign tmr.QH      = cnt_q[6:4];
  assign tmr.QL      = cnt_q[3:0];
  assign tmr.BW      = bw_q;
  assign tmr.RUNNING = running_q;
  assign tmr.EXPIRED = expired_q;

endmodule
